overload_trip_controller: RTL and testbench
===========================================

// Module: overload_trip_controller
// PURPOSE
//  Consumes the per-cycle over_load flag from the energy meter and drives the load breaker relay.
//  Trips only on a persistent overload, then auto-recloses after a cooldown.
//  Locks out after MAX_RETRY trips until an operator clears it.
//  Sits between the meter's over_load output and the relay/contactor driver.
// PARAMETERS
//  TRIP_DELAY    4   consecutive sampled over_load=1 cycles needed to trip (>=1)
//  COOLDOWN      8   cycles breaker stays open after a trip before reclose (>=1)
//  MAX_RETRY     2   trips allowed before lockout; the (MAX_RETRY+1)th trip locks out (>=0)
//  STABLE_CYCLES 16  clean ARMED cycles that reset retry_cnt to 0 (>=1)
//  CNT_W         16  width of the internal timers; must hold max(TRIP_DELAY,COOLDOWN,STABLE_CYCLES)
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-high; overrides every other input
//  enable        in   1      arm the protection/breaker; low = breaker open, counters cleared
//  over_load     in   1      overload flag from energy meter, sampled each rising edge
//  clear_lockout in   1      operator clear; acted on only in LOCKOUT with over_load=0
//  breaker_on    out  1      relay drive, 1 = load connected
//  tripped       out  1      1 while in TRIPPED (cooldown)
//  lockout       out  1      1 while in LOCKOUT
//  trip_event    out  1      one-cycle pulse on every entry to TRIPPED or LOCKOUT
//  retry_cnt     out  2      trips since last clean period; saturates at MAX_RETRY+1
//  state         out  3      current state encoding, for debug/status
// BEHAVIOUR
//  - All outputs registered. Reset values: state=IDLE, breaker_on=0, tripped=0, lockout=0,
//    trip_event=0, retry_cnt=0. Reset is applied on the next edge.
//  - Output decode from the registered state: breaker_on=1 in ARMED/PENDING only;
//    tripped=(TRIPPED); lockout=(LOCKOUT).
//  - States:
//    IDLE:    enable=1 -> ARMED.
//    ARMED:   over_load=1 -> PENDING with pcnt=1. If TRIP_DELAY==1, go straight to trip.
//             Otherwise clean_cnt++; at clean_cnt==STABLE_CYCLES, clear retry_cnt and clean_cnt.
//    PENDING: over_load=0 -> ARMED, pcnt=0 (persistence must be consecutive).
//             Else pcnt++; when pcnt reaches TRIP_DELAY -> trip.
//    trip:    retry_cnt++, pulse trip_event, clean_cnt=0.
//             If the new retry_cnt > MAX_RETRY -> LOCKOUT, else -> TRIPPED with ccnt=0.
//    TRIPPED: ccnt++; after COOLDOWN cycles in TRIPPED -> ARMED (reclose).
//             The over_load value during cooldown is ignored.
//    LOCKOUT: hold. clear_lockout=1 && over_load=0 -> IDLE and retry_cnt=0.
//             clear_lockout with over_load=1 is ignored.
//  - Latency: trip is registered on the TRIP_DELAY-th consecutive edge sampling over_load=1.
//    breaker_on falls and trip_event rises on that same edge.
//  - enable=0 in IDLE/ARMED/PENDING/TRIPPED -> IDLE next edge and clears pcnt, ccnt,
//    clean_cnt, retry_cnt. enable=0 is ignored in LOCKOUT; only clear_lockout exits it.
//  - Simultaneous events:
//    reset > enable=0 > trip condition > clean/stable logic.
//    A trip completing on the same edge clean_cnt would hit STABLE_CYCLES: the trip wins,
//    and retry_cnt is incremented, not cleared.
//  - Counters never wrap: each timer stops at its terminal value and the state changes.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE=0, ARMED=1, PENDING=2, TRIPPED=3,
//    LOCKOUT=4) and the 3-bit state width. This lets the meter top level and status
//    logic decode state.
//  - One sub-module, trip_timer: CNT_W-bit up-counter with clear, enable, and terminal
//    compare against a runtime limit. Instantiate it three times: persistence (pcnt),
//    cooldown (ccnt), stable (clean_cnt).
//  - Top: single next-state always block plus a registered output block.
// TESTING (TRIP_DELAY=4, COOLDOWN=8, MAX_RETRY=2, STABLE_CYCLES=16)
//  1. reset 2 cycles, then enable=1 -> state ARMED and breaker_on=1 one edge after enable
//     is sampled; all other outputs 0.
//  2. over_load=1 for 3 edges then 0 -> no trip, breaker_on stays 1, retry_cnt=0,
//     state returns to ARMED.
//  3. over_load held 1 -> on the 4th edge breaker_on=0, tripped=1, trip_event=1 for one
//     cycle, retry_cnt=1. Drop over_load -> breaker_on=1 again 8 cycles later.
//  4. Force 3 trips without a 16-cycle clean gap -> 3rd trip gives lockout=1, retry_cnt=3,
//     breaker_on=0. enable toggle and clear_lockout with over_load=1 -> no change.
//     clear_lockout with over_load=0 -> IDLE, retry_cnt=0, then ARMED.
//  5. After 1 trip and reclose, hold over_load=0 for 16 cycles -> retry_cnt returns to 0.
//     Next two trips do not lock out.
//  6. Assert reset in PENDING (pcnt=3) and in TRIPPED -> next edge state=IDLE with all
//     outputs 0. Deassert enable mid-cooldown -> IDLE and retry_cnt=0.

Source files
------------

// File: rtl/overload_trip_controller_pkg.sv
// Shared state encodings for the overload trip controller, so status and top-level
// logic can decode the exported state value.
package overload_trip_controller_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_PENDING = 3'd2,
      ST_TRIPPED = 3'd3,
      ST_LOCKOUT = 3'd4
   } trip_state_t;

endpackage

// File: rtl/overload_trip_controller_trip_timer.sv
// Saturating up-counter with clear/enable and a terminal flag against a runtime limit.
// Clear wins over enable; the count holds once it equals the limit.
module overload_trip_controller_trip_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !done) begin
         count <= count + 1'b1;
      end
   end

   assign done = (count == limit);

endmodule

// File: rtl/overload_trip_controller.sv
// Breaker control: trips on persistent over_load, auto-recloses after a cooldown,
// and locks out after too many trips until an operator clears it.
module overload_trip_controller
   import overload_trip_controller_pkg::*;
#(
   parameter int TRIP_DELAY    = 4,
   parameter int COOLDOWN      = 8,
   parameter int MAX_RETRY     = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               over_load,
   input  logic               clear_lockout,
   output logic               breaker_on,
   output logic               tripped,
   output logic               lockout,
   output logic               trip_event,
   output logic [1:0]         retry_cnt,
   output logic [STATE_W-1:0] state
);

   // Timers flag "done" one edge early so the transition lands on the Nth edge.
   localparam logic [CNT_W-1:0] P_LIMIT = CNT_W'(TRIP_DELAY - 1);
   localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(COOLDOWN - 1);
   localparam logic [CNT_W-1:0] S_LIMIT = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [1:0]       RETRY_SAT = 2'(MAX_RETRY + 1);

   trip_state_t state_q, state_d;
   logic [1:0]  retry_q, retry_d, retry_inc;
   logic        trip, go_idle;
   logic        p_clr, p_inc, p_done;
   logic        c_clr, c_inc, c_done;
   logic        s_clr, s_inc, s_done;

   assign retry_inc = (retry_q == RETRY_SAT) ? RETRY_SAT : retry_q + 2'd1;

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      trip    = 1'b0;
      go_idle = 1'b0;
      p_clr   = 1'b0;
      p_inc   = 1'b0;
      c_clr   = 1'b0;
      c_inc   = 1'b0;
      s_clr   = 1'b0;
      s_inc   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            p_clr = 1'b1;
            c_clr = 1'b1;
            s_clr = 1'b1;
            if (enable) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!enable) begin
               go_idle = 1'b1;
            end else if (over_load) begin
               if (TRIP_DELAY == 1) begin
                  trip = 1'b1;
               end else begin
                  state_d = ST_PENDING;
                  p_inc   = 1'b1;
               end
            end else if (s_done) begin
               retry_d = 2'd0;
               s_clr   = 1'b1;
            end else begin
               s_inc = 1'b1;
            end
         end
         ST_PENDING: begin
            if (!enable) begin
               go_idle = 1'b1;
            end else if (!over_load) begin
               state_d = ST_ARMED;
               p_clr   = 1'b1;
            end else if (p_done) begin
               trip = 1'b1;
            end else begin
               p_inc = 1'b1;
            end
         end
         ST_TRIPPED: begin
            if (!enable) begin
               go_idle = 1'b1;
            end else if (c_done) begin
               state_d = ST_ARMED;
               c_clr   = 1'b1;
            end else begin
               c_inc = 1'b1;
            end
         end
         ST_LOCKOUT: begin
            // enable is deliberately ignored here; only an operator clear exits.
            if (clear_lockout && !over_load) begin
               state_d = ST_IDLE;
               retry_d = 2'd0;
            end
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (go_idle) begin
         state_d = ST_IDLE;
         retry_d = 2'd0;
         p_clr   = 1'b1;
         c_clr   = 1'b1;
         s_clr   = 1'b1;
      end else if (trip) begin
         // Trip beats the stable-period clear that may coincide on this edge.
         retry_d = retry_inc;
         p_clr   = 1'b1;
         c_clr   = 1'b1;
         s_clr   = 1'b1;
         state_d = (retry_inc == RETRY_SAT) ? ST_LOCKOUT : ST_TRIPPED;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         breaker_on <= 1'b0;
         tripped    <= 1'b0;
         lockout    <= 1'b0;
         trip_event <= 1'b0;
         retry_q    <= 2'd0;
      end else begin
         breaker_on <= (state_d == ST_ARMED) || (state_d == ST_PENDING);
         tripped    <= (state_d == ST_TRIPPED);
         lockout    <= (state_d == ST_LOCKOUT);
         trip_event <= trip;
         retry_q    <= retry_d;
      end
   end

   assign retry_cnt = retry_q;
   assign state     = state_q;

   overload_trip_controller_trip_timer #(.CNT_W(CNT_W)) u_pcnt (
      .clk(clk), .reset(reset), .clear(p_clr), .enable(p_inc), .limit(P_LIMIT), .done(p_done)
   );

   overload_trip_controller_trip_timer #(.CNT_W(CNT_W)) u_ccnt (
      .clk(clk), .reset(reset), .clear(c_clr), .enable(c_inc), .limit(C_LIMIT), .done(c_done)
   );

   overload_trip_controller_trip_timer #(.CNT_W(CNT_W)) u_clean (
      .clk(clk), .reset(reset), .clear(s_clr), .enable(s_inc), .limit(S_LIMIT), .done(s_done)
   );

endmodule

// File: tb/tb_overload_trip_controller.sv
// Directed bench for overload_trip_controller with hand-computed expectations.
module tb_overload_trip_controller;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_PENDING = 3'd2;
   localparam logic [2:0] S_TRIPPED = 3'd3;
   localparam logic [2:0] S_LOCKOUT = 3'd4;

   logic       clk = 1'b0;
   logic       reset, enable, over_load, clear_lockout;
   logic       breaker_on, tripped, lockout, trip_event;
   logic [1:0] retry_cnt;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;

   overload_trip_controller #(
      .TRIP_DELAY(4), .COOLDOWN(8), .MAX_RETRY(2), .STABLE_CYCLES(16), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .over_load(over_load),
      .clear_lockout(clear_lockout), .breaker_on(breaker_on), .tripped(tripped),
      .lockout(lockout), .trip_event(trip_event), .retry_cnt(retry_cnt), .state(state)
   );

   always #5 clk = ~clk;

   // Advance n edges; outputs are sampled 1 time unit after the edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st, input logic br,
                          input logic tr, input logic lo, input logic te, input logic [1:0] rc);
      chk({tag, ".state"}, 8'(state), 8'(st));
      chk({tag, ".breaker_on"}, 8'(breaker_on), 8'(br));
      chk({tag, ".tripped"}, 8'(tripped), 8'(tr));
      chk({tag, ".lockout"}, 8'(lockout), 8'(lo));
      chk({tag, ".trip_event"}, 8'(trip_event), 8'(te));
      chk({tag, ".retry_cnt"}, 8'(retry_cnt), 8'(rc));
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; over_load = 1'b0; clear_lockout = 1'b0;
      #1;
      tick(2);
      chk_all("reset", S_IDLE, 0, 0, 0, 0, 2'd0);

      reset = 1'b0; enable = 1'b1;
      tick(1);
      chk_all("arm", S_ARMED, 1, 0, 0, 0, 2'd0);

      // Short overload burst: no trip.
      over_load = 1'b1;
      tick(1);
      chk_all("burst1", S_PENDING, 1, 0, 0, 0, 2'd0);
      tick(2);
      chk_all("burst3", S_PENDING, 1, 0, 0, 0, 2'd0);
      over_load = 1'b0;
      tick(1);
      chk_all("burst_end", S_ARMED, 1, 0, 0, 0, 2'd0);

      // First trip on the 4th consecutive edge.
      over_load = 1'b1;
      tick(3);
      chk_all("trip1_pre", S_PENDING, 1, 0, 0, 0, 2'd0);
      tick(1);
      chk_all("trip1", S_TRIPPED, 0, 1, 0, 1, 2'd1);
      over_load = 1'b0;
      tick(1);
      chk_all("cool1_1", S_TRIPPED, 0, 1, 0, 0, 2'd1);
      tick(6);
      chk_all("cool1_7", S_TRIPPED, 0, 1, 0, 0, 2'd1);
      tick(1);
      chk_all("reclose1", S_ARMED, 1, 0, 0, 0, 2'd1);

      // Second trip; over_load held during cooldown is ignored.
      over_load = 1'b1;
      tick(4);
      chk_all("trip2", S_TRIPPED, 0, 1, 0, 1, 2'd2);
      tick(7);
      chk_all("cool2_7", S_TRIPPED, 0, 1, 0, 0, 2'd2);
      over_load = 1'b0;
      tick(1);
      chk_all("reclose2", S_ARMED, 1, 0, 0, 0, 2'd2);

      // Third trip locks out.
      over_load = 1'b1;
      tick(4);
      chk_all("lock", S_LOCKOUT, 0, 0, 1, 1, 2'd3);
      tick(1);
      chk_all("lock_hold", S_LOCKOUT, 0, 0, 1, 0, 2'd3);
      enable = 1'b0;
      tick(1);
      chk_all("lock_en0", S_LOCKOUT, 0, 0, 1, 0, 2'd3);
      enable = 1'b1;
      tick(1);
      chk_all("lock_en1", S_LOCKOUT, 0, 0, 1, 0, 2'd3);
      clear_lockout = 1'b1;
      tick(1);
      chk_all("clear_ovl", S_LOCKOUT, 0, 0, 1, 0, 2'd3);
      over_load = 1'b0;
      tick(1);
      chk_all("clear_ok", S_IDLE, 0, 0, 0, 0, 2'd0);
      clear_lockout = 1'b0;
      tick(1);
      chk_all("rearm", S_ARMED, 1, 0, 0, 0, 2'd0);

      // Clean period clears retry count.
      over_load = 1'b1;
      tick(4);
      chk_all("t5_trip", S_TRIPPED, 0, 1, 0, 1, 2'd1);
      over_load = 1'b0;
      tick(8);
      chk_all("t5_reclose", S_ARMED, 1, 0, 0, 0, 2'd1);
      tick(15);
      chk_all("clean15", S_ARMED, 1, 0, 0, 0, 2'd1);
      tick(1);
      chk_all("clean16", S_ARMED, 1, 0, 0, 0, 2'd0);
      over_load = 1'b1;
      tick(4);
      chk_all("t5_tripA", S_TRIPPED, 0, 1, 0, 1, 2'd1);
      over_load = 1'b0;
      tick(8);
      over_load = 1'b1;
      tick(4);
      chk_all("t5_tripB", S_TRIPPED, 0, 1, 0, 1, 2'd2);

      // Reset in TRIPPED.
      over_load = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
      chk_all("rst_tripped", S_IDLE, 0, 0, 0, 0, 2'd0);

      // Reset in PENDING with pcnt=3.
      reset = 1'b0;
      tick(1);
      chk_all("rst_rearm", S_ARMED, 1, 0, 0, 0, 2'd0);
      over_load = 1'b1;
      tick(3);
      chk_all("pend3", S_PENDING, 1, 0, 0, 0, 2'd0);
      reset = 1'b1;
      tick(1);
      chk_all("rst_pending", S_IDLE, 0, 0, 0, 0, 2'd0);

      // Persistence restarts after reset: three more overload edges must not trip.
      reset = 1'b0;
      tick(1);
      tick(3);
      chk_all("pend_fresh", S_PENDING, 1, 0, 0, 0, 2'd0);
      tick(1);
      chk_all("trip6", S_TRIPPED, 0, 1, 0, 1, 2'd1);

      // enable=0 mid-cooldown.
      over_load = 1'b0;
      tick(3);
      enable = 1'b0;
      tick(1);
      chk_all("disable_cool", S_IDLE, 0, 0, 0, 0, 2'd0);
      tick(2);
      chk_all("idle_hold", S_IDLE, 0, 0, 0, 0, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
